// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready register chain of DEPTH slots with global stall, flush
// (bubble insertion) and bubble collapsing. Slot 0 faces the producer.
module pipe_stage_elastic #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [WIDTH-1:0]           out_data_o,
  input  logic                       out_ready_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             go;
  logic             in_xfer;

  // A slot advances when it is valid and the slot ahead is empty or itself
  // advancing; the scalar 'go' carries that decision from the output end back.
  always_comb begin : advance
    // NOTE: every combinationally assigned signal gets a default first, so no path leaves it unassigned and infers a latch.
    adv = '0;
    go  = 1'b0;
    if (!stall_i && !flush_i) begin
      go           = v_q[DEPTH-1] & out_ready_i;
      adv[DEPTH-1] = go;
      for (int k = DEPTH - 2; k >= 0; k--) begin
        go     = v_q[k] & (~v_q[k+1] | go);
        adv[k] = go;
      end
    end
  end

  // Depends only on state, stall/flush and out_ready_i, never on in_valid_i.
  assign in_ready_o = rst_i & ~stall_i & ~flush_i & (~v_q[0] | adv[0]);
  assign in_xfer    = in_valid_i & in_ready_o;

  always_comb begin : next_state
    v_d = v_q;
    d_d = d_q;
    // Vacate every advancing slot first; the forward moves below refill it.
    for (int k = 0; k < DEPTH; k++) begin
      if (adv[k]) begin
        v_d[k] = 1'b0;
        d_d[k] = '0;
      end
    end
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (adv[k]) begin
        v_d[k+1] = 1'b1;
        d_d[k+1] = d_q[k];
      end
    end
    if (in_xfer) begin
      v_d[0] = 1'b1;
      d_d[0] = in_data_i;
    end
    if (flush_i) begin
      v_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_d[k] = '0;
      end
    end
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + OCC_W'(v_d[k]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v_q   <= '0;
      occ_q <= '0;
      // NOTE: the payload array is reset as well, because an empty slot must always read as zero, including straight after reset.
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments so every slot samples its neighbour's pre-edge value.
      v_q   <= v_d;
      d_q   <= d_d;
      occ_q <= occ_d;
    end
  end

  assign out_valid_o = v_q[DEPTH-1];
  assign out_data_o  = d_q[DEPTH-1];
  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed scenarios on a DEPTH=3 chain plus a
// randomised run of DEPTH 1, 2, 3 and 8 chains against per-chain scoreboards.
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        stall;
  logic        flush;

  logic [3:0]  ir;
  logic [3:0]  ov;
  logic [31:0] od [4];
  logic [3:0]  occ_a [4];
  logic [0:0]  occ1;
  logic [1:0]  occ2;
  logic [1:0]  occ3;
  logic [3:0]  occ8;

  int          checks = 0;
  int          errors = 0;
  int          depths [4] = '{1, 2, 3, 8};
  logic [31:0] sbq [4][$];

  always #5 clk = ~clk;

  assign occ_a[0] = {3'b000, occ1};
  assign occ_a[1] = {2'b00, occ2};
  assign occ_a[2] = {2'b00, occ3};
  assign occ_a[3] = occ8;

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(ir[0]), .out_valid_o(ov[0]), .out_data_o(od[0]),
    .out_ready_i(out_ready), .stall_i(stall), .flush_i(flush), .occupancy_o(occ1));

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(2)) u_d2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(ir[1]), .out_valid_o(ov[1]), .out_data_o(od[1]),
    .out_ready_i(out_ready), .stall_i(stall), .flush_i(flush), .occupancy_o(occ2));

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(3)) u_d3 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(ir[2]), .out_valid_o(ov[2]), .out_data_o(od[2]),
    .out_ready_i(out_ready), .stall_i(stall), .flush_i(flush), .occupancy_o(occ3));

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(8)) u_d8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(ir[3]), .out_valid_o(ov[3]), .out_data_o(od[3]),
    .out_ready_i(out_ready), .stall_i(stall), .flush_i(flush), .occupancy_o(occ8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #3;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || od[i] !== '0 || occ_a[i] !== '0 || ir[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: valid=%b data=%h occ=%0d ready=%b, required all zero",
                 i, ov[i], od[i], occ_a[i], ir[i]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 32'h55;
    tick();
    in_data  = 32'h66;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (occ_a[2] !== 4'd2) begin
      errors++;
      $display("FAIL pre_reset_occ: got %0d required 2", occ_a[2]);
    end
    checks++;
    if (ov[0] !== 1'b1 || od[0] !== 32'h55) begin
      errors++;
      $display("FAIL pre_reset_d1: valid=%b data=%h required 1/55", ov[0], od[0]);
    end
    // Drop reset between clock edges: clearing must not wait for clk.
    #2;
    rst = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || od[i] !== '0 || occ_a[i] !== '0 || ir[i] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset[%0d]: valid=%b data=%h occ=%0d ready=%b, required all zero",
                 i, ov[i], od[i], occ_a[i], ir[i]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    int          exp_occ [4] = '{1, 1, 1, 0};
    logic        exp_ov  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp_od  [4] = '{32'h0, 32'h0, 32'h11, 32'h0};
    idle();
    in_valid  = 1'b1;
    in_data   = 32'h11;
    out_ready = 1'b1;
    #1;
    checks++;
    if (ir[2] !== 1'b1) begin
      errors++;
      $display("FAIL lat_accept: ready=%b required 1", ir[2]);
    end
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (int'(occ_a[2]) !== exp_occ[k] || ov[2] !== exp_ov[k] || od[2] !== exp_od[k]) begin
        errors++;
        $display("FAIL latency[edge+%0d]: occ=%0d valid=%b data=%h required occ=%0d valid=%b data=%h",
                 k, occ_a[2], ov[2], od[2], exp_occ[k], exp_ov[k], exp_od[k]);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [31:0] q[$];
    logic [31:0] got;
    logic        taken;
    idle();
    taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA + 32'(i);
      #1;
      checks++;
      if (ir[2] !== 1'(i < 3)) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b required %b", i, ir[2], (i < 3));
      end
      if (ir[2]) begin
        q.push_back(in_data);
        if (i == 3) taken = 1'b1;
      end
      tick();
    end
    if (taken) in_valid = 1'b0;
    #1;
    checks++;
    if (occ_a[2] !== 4'd3 || ov[2] !== 1'b1 || od[2] !== 32'hA) begin
      errors++;
      $display("FAIL bp_full: occ=%0d valid=%b data=%h required 3/1/a", occ_a[2], ov[2], od[2]);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      if (in_valid && ir[2]) begin
        q.push_back(in_data);
        taken = 1'b1;
      end
      checks++;
      if (ov[2] !== 1'b1) begin
        errors++;
        $display("FAIL bp_drain_gap[%0d]: valid=%b required 1", j, ov[2]);
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL bp_drain_extra[%0d]: data=%h with nothing expected", j, od[2]);
      end else begin
        got = q.pop_front();
        if (od[2] !== got) begin
          errors++;
          $display("FAIL bp_drain_data[%0d]: got %h required %h", j, od[2], got);
        end
      end
      tick();
      if (taken) in_valid = 1'b0;
    end
    #1;
    checks++;
    if (q.size() != 0 || occ_a[2] !== 4'd0 || ov[2] !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: pending=%0d occ=%0d valid=%b required 0/0/0", q.size(), occ_a[2], ov[2]);
    end
    idle();
  endtask

  task automatic test_throughput();
    logic [31:0] q[$];
    logic [31:0] got;
    int          ngot;
    int          first;
    idle();
    ngot      = 0;
    first     = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 110; c++) begin
      in_valid = (c < 100);
      in_data  = 32'h1000 + 32'(c);
      #1;
      if (in_valid) begin
        checks++;
        if (ir[2] !== 1'b1) begin
          errors++;
          $display("FAIL tp_ready[%0d]: got %b required 1", c, ir[2]);
        end else begin
          q.push_back(in_data);
        end
      end
      if (ov[2]) begin
        if (first < 0) first = c;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL tp_extra[%0d]: data=%h with nothing expected", c, od[2]);
        end else begin
          got = q.pop_front();
          if (od[2] !== got) begin
            errors++;
            $display("FAIL tp_data[%0d]: got %h required %h", c, od[2], got);
          end
        end
        ngot++;
      end else if (first >= 0 && ngot < 100) begin
        checks++;
        errors++;
        $display("FAIL tp_gap[%0d]: valid=0 after %0d outputs, required 1", c, ngot);
      end
      tick();
    end
    checks++;
    if (ngot != 100 || first != 3) begin
      errors++;
      $display("FAIL tp_total: outputs=%0d first_cycle=%0d required 100/3", ngot, first);
    end
    idle();
  endtask

  task automatic test_stall();
    logic [31:0] q[$];
    logic [31:0] got;
    int          seen;
    idle();
    seen = 0;
    for (int w = 1; w <= 2; w++) begin
      in_valid = 1'b1;
      in_data  = 32'(w);
      #1;
      checks++;
      if (ir[2] !== 1'b1) begin
        errors++;
        $display("FAIL stall_load[%0d]: ready=%b required 1", w, ir[2]);
      end else begin
        q.push_back(in_data);
      end
      tick();
    end
    stall     = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'h99;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (ir[2] !== 1'b0 || occ_a[2] !== 4'd2 || ov[2] !== 1'b0 || od[2] !== '0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: ready=%b occ=%0d valid=%b data=%h required 0/2/0/0",
                 c, ir[2], occ_a[2], ov[2], od[2]);
      end
      if (c < 4) tick();
    end
    stall    = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (ov[2]) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stall_extra[%0d]: data=%h with nothing expected", c, od[2]);
        end else begin
          got = q.pop_front();
          seen++;
          if (od[2] !== got) begin
            errors++;
            $display("FAIL stall_data[%0d]: got %h required %h", c, od[2], got);
          end
        end
      end
      tick();
    end
    checks++;
    if (seen != 2 || occ_a[2] !== 4'd0) begin
      errors++;
      $display("FAIL stall_release: delivered=%0d occ=%0d required 2/0", seen, occ_a[2]);
    end
    idle();
  endtask

  task automatic test_flush();
    logic found;
    idle();
    found = 1'b0;
    for (int w = 0; w < 3; w++) begin
      in_valid = 1'b1;
      in_data  = 32'h31 + 32'(w);
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (occ_a[2] !== 4'd3) begin
      errors++;
      $display("FAIL flush_fill: occ=%0d required 3", occ_a[2]);
    end
    flush     = 1'b1;
    stall     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD;
    out_ready = 1'b1;
    #1;
    checks++;
    if (ir[2] !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got %b required 0", ir[2]);
    end
    tick();
    flush    = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (occ_a[2] !== 4'd0 || ov[2] !== 1'b0 || od[2] !== '0) begin
      errors++;
      $display("FAIL flush_clear: occ=%0d valid=%b data=%h required all zero", occ_a[2], ov[2], od[2]);
    end
    in_valid = 1'b1;
    in_data  = 32'h44;
    #1;
    checks++;
    if (ir[2] !== 1'b1) begin
      errors++;
      $display("FAIL flush_reaccept: ready=%b required 1", ir[2]);
    end
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (ov[2] && !found) begin
        found = 1'b1;
        checks++;
        if (od[2] !== 32'h44) begin
          errors++;
          $display("FAIL flush_first: got %h required 44", od[2]);
        end
      end
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL flush_timeout: no output within 10 cycles, required 44");
    end
    idle();
  endtask

  task automatic test_random();
    logic        exp_rdy;
    logic [31:0] got;
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) sbq[i].delete();
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      stall     = ($urandom_range(0, 99) < 10);
      flush     = ($urandom_range(0, 99) < 2);
      #1;
      for (int i = 0; i < 4; i++) begin
        // A chain with any empty slot can always take input; a full one only when the output drains.
        exp_rdy = !stall && !flush && (sbq[i].size() < depths[i] || out_ready);
        checks++;
        if (ir[i] !== exp_rdy) begin
          errors++;
          $display("FAIL rnd_ready[d%0d,%0d]: got %b required %b", depths[i], n, ir[i], exp_rdy);
        end
        checks++;
        if (int'(occ_a[i]) !== sbq[i].size()) begin
          errors++;
          $display("FAIL rnd_occ[d%0d,%0d]: got %0d required %0d", depths[i], n, occ_a[i], sbq[i].size());
        end
        if (!ov[i]) begin
          checks++;
          if (od[i] !== '0) begin
            errors++;
            $display("FAIL rnd_zero[d%0d,%0d]: data=%h with valid=0, required 0", depths[i], n, od[i]);
          end
        end
        if (flush) begin
          sbq[i].delete();
        end else begin
          if (ov[i] && out_ready && !stall) begin
            checks++;
            if (sbq[i].size() == 0) begin
              errors++;
              $display("FAIL rnd_extra[d%0d,%0d]: data=%h with nothing expected", depths[i], n, od[i]);
            end else begin
              got = sbq[i].pop_front();
              if (od[i] !== got) begin
                errors++;
                $display("FAIL rnd_data[d%0d,%0d]: got %h required %h", depths[i], n, od[i], got);
              end
            end
          end
          if (in_valid && ir[i]) sbq[i].push_back(in_data);
        end
      end
      tick();
    end
    idle();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      for (int i = 0; i < 4; i++) begin
        if (ov[i]) begin
          checks++;
          if (sbq[i].size() == 0) begin
            errors++;
            $display("FAIL drain_extra[d%0d]: data=%h with nothing expected", depths[i], od[i]);
          end else begin
            got = sbq[i].pop_front();
            if (od[i] !== got) begin
              errors++;
              $display("FAIL drain_data[d%0d]: got %h required %h", depths[i], od[i], got);
            end
          end
        end
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sbq[i].size() != 0 || occ_a[i] !== 4'd0) begin
        errors++;
        $display("FAIL drain_empty[d%0d]: pending=%0d occ=%0d required 0/0", depths[i], sbq[i].size(), occ_a[i]);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_throughput();
    test_stall();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
